// File: rtl/procyon_fifo_reader.sv
// Sync-FIFO read-side consumer: issues pops, captures the one-cycle-late read
// data into a small circular skid buffer and presents it as a valid/ready stream.

module procyon_fifo_reader_chk #(
    parameter int DEPTH = 3,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst,
    input logic [CW-1:0] count,
    input logic          inflight
);

    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, count} + {{CW{1'b0}}, inflight}) <= DEPTH_W));

endmodule

module procyon_fifo_reader #(
    parameter int OPTN_DATA_WIDTH = 8,
    parameter int OPTN_BUF_DEPTH  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_fifo_valid,
    input  logic [OPTN_DATA_WIDTH-1:0] i_fifo_data,
    output logic                       o_fifo_ack,
    output logic                       o_valid,
    output logic [OPTN_DATA_WIDTH-1:0] o_data,
    input  logic                       i_ready
);

    localparam int CW = $clog2(OPTN_BUF_DEPTH + 1);
    localparam int IW = $clog2(OPTN_BUF_DEPTH);
    localparam logic [CW:0]   DEPTH_W  = (CW+1)'(OPTN_BUF_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(OPTN_BUF_DEPTH - 1);

    logic [OPTN_DATA_WIDTH-1:0] buf_r [OPTN_BUF_DEPTH];
    logic [IW-1:0]              head_r;
    logic [IW-1:0]              tail_r;
    logic [CW-1:0]              count_r;
    logic                       inflight_r;

    logic                       clear_s;
    logic                       ack_s;
    logic                       push_s;
    logic                       pop_s;
    logic [CW:0]                occupancy_s;
    logic [CW-1:0]              count_nxt_s;
    logic [IW-1:0]              head_nxt_s;
    logic [IW-1:0]              tail_nxt_s;

    // Circular increment that also wraps correctly for non-power-of-2 depths.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        if (idx == LAST_IDX) begin
            next_idx = {IW{1'b0}};
        end else begin
            next_idx = idx + IW'(1);
        end
    endfunction

    // Pop request, capture/pop qualification and next-state computation.
    always_comb begin
        clear_s     = rst | i_flush;
        // Inflight word already owns a slot, so it counts toward occupancy.
        occupancy_s = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
        ack_s       = i_fifo_valid & ~clear_s & (occupancy_s < DEPTH_W);
        push_s      = inflight_r & ~clear_s;
        pop_s       = (count_r != {CW{1'b0}}) & i_ready & ~clear_s;

        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end

        head_nxt_s = head_r;
        if (pop_s) begin
            head_nxt_s = next_idx(head_r);
        end else begin
            head_nxt_s = head_r;
        end

        tail_nxt_s = tail_r;
        if (push_s) begin
            tail_nxt_s = next_idx(tail_r);
        end else begin
            tail_nxt_s = tail_r;
        end
    end

    // Control state; reset and flush both empty the buffer and drop any inflight word.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            head_r     <= {IW{1'b0}};
            tail_r     <= {IW{1'b0}};
            count_r    <= {CW{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            count_r    <= count_nxt_s;
            inflight_r <= ack_s;
        end
    end

    // Data storage is deliberately not reset; o_data is qualified by o_valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            buf_r[tail_r] <= i_fifo_data;
        end
    end

    assign o_fifo_ack = ack_s;
    assign o_valid    = (count_r != {CW{1'b0}});
    assign o_data     = buf_r[head_r];

    procyon_fifo_reader_chk #(
        .DEPTH (OPTN_BUF_DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .count    (count_r),
        .inflight (inflight_r)
    );

endmodule

// File: tb/tb_procyon_fifo_reader.sv
// Randomized bench for procyon_fifo_reader at depths 3, 2 and 5, checked every
// cycle against a word-index model of the upstream FIFO and the output stream.

module tb_procyon_fifo_reader;

    localparam int W  = 8;
    localparam int NS = 2048;
    localparam int ND = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         ready;
    logic         fv;
    logic [W-1:0] fdata [ND];
    logic         ack   [ND];
    logic         oval  [ND];
    logic [W-1:0] odata [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int D = (g == 0) ? 3 : ((g == 1) ? 2 : 5);
        procyon_fifo_reader #(
            .OPTN_DATA_WIDTH (W),
            .OPTN_BUF_DEPTH  (D)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .i_flush      (flush),
            .i_fifo_valid (fv),
            .i_fifo_data  (fdata[g]),
            .o_fifo_ack   (ack[g]),
            .o_valid      (oval[g]),
            .o_data       (odata[g]),
            .i_ready      (ready)
        );
    end

    typedef struct {
        int len;
        int vm;     // 0 off, 1 on, 2 random
        int rm;     // 0 zero, 1 one, 2 alternate, 3 random
        int cm;     // 0 none, 1 flush first cycle, 2 rst all cycles, 3 random flush/rst
        int tagw;   // -1, or a word forced as the next one each DUT pops
        bit thr;    // count depth-3 deliveries over this segment
    } seg_t;

    seg_t         segs [$];
    int           dep [ND] = '{3, 2, 5};
    logic [W-1:0] srcw [ND][NS];
    int           popped [ND];
    int           arrived [ND];
    int           delivered [ND];
    bit           last_ack [ND];
    bit           e_ack [ND];
    bit           e_del [ND];
    bit           e_inf [ND];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           thr_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < ND; k++) begin
            for (int i = 0; i < NS; i++) srcw[k][i] = W'($urandom);
            srcw[k][0] = 8'h11; srcw[k][1] = 8'h22; srcw[k][2] = 8'h33; srcw[k][3] = 8'h44;
            popped[k] = 0; arrived[k] = 0; delivered[k] = 0; last_ack[k] = 1'b0;
            fdata[k] = '0;
        end
        rst = 1'b1; flush = 1'b0; ready = 1'b0; fv = 1'b0;

        segs.push_back('{3,   0, 1, 2, -1,    1'b0});  // reset
        segs.push_back('{10,  1, 1, 0, -1,    1'b0});  // 0x11..0x44 streamed
        segs.push_back('{12,  1, 0, 0, -1,    1'b0});  // backpressure fills buffer
        segs.push_back('{15,  1, 1, 0, -1,    1'b0});  // drain
        segs.push_back('{40,  1, 2, 0, -1,    1'b0});  // alternating ready
        segs.push_back('{6,   0, 1, 0, -1,    1'b0});  // empty out
        segs.push_back('{1,   1, 1, 0, 8'hAB, 1'b0});  // ack 0xAB
        segs.push_back('{1,   0, 1, 1, -1,    1'b0});  // flush while 0xAB returns
        segs.push_back('{4,   0, 1, 0, -1,    1'b0});
        segs.push_back('{40,  1, 1, 0, -1,    1'b1});  // full throughput from empty
        segs.push_back('{6,   1, 0, 0, -1,    1'b0});  // buffer + inflight pending
        segs.push_back('{1,   1, 0, 2, -1,    1'b0});  // mid-stream reset
        segs.push_back('{10,  1, 1, 0, 8'h5A, 1'b0});  // fresh word first
        segs.push_back('{600, 2, 3, 3, -1,    1'b0});  // random traffic

        foreach (segs[s]) begin
            thr_cnt = 0;
            if (segs[s].tagw >= 0) begin
                for (int k = 0; k < ND; k++) srcw[k][popped[k]] = W'(segs[s].tagw);
            end
            for (int c = 0; c < segs[s].len; c++) begin
                @(negedge clk);
                cyc++;
                rst   = (segs[s].cm == 2) || (segs[s].cm == 3 && $urandom_range(63) == 0);
                flush = (segs[s].cm == 1 && c == 0) || (segs[s].cm == 3 && $urandom_range(15) == 0);
                case (segs[s].vm)
                    0:       fv = 1'b0;
                    1:       fv = 1'b1;
                    default: fv = ($urandom_range(3) != 0);
                endcase
                case (segs[s].rm)
                    0:       ready = 1'b0;
                    1:       ready = 1'b1;
                    2:       ready = cyc[0];
                    default: ready = ($urandom_range(2) != 0);
                endcase
                for (int k = 0; k < ND; k++) begin
                    fdata[k] = last_ack[k] ? srcw[k][popped[k] - 1] : W'($urandom);
                end
                #1;
                for (int k = 0; k < ND; k++) begin
                    int cnt;
                    cnt      = arrived[k] - delivered[k];
                    e_inf[k] = (popped[k] != arrived[k]);
                    e_ack[k] = fv && !rst && !flush && (cnt + int'(e_inf[k]) < dep[k]);
                    e_del[k] = (cnt != 0) && ready;
                    check_val($sformatf("ack d%0d c%0d", dep[k], cyc), 32'(ack[k]), 32'(e_ack[k]));
                    check_val($sformatf("valid d%0d c%0d", dep[k], cyc), 32'(oval[k]), 32'(cnt != 0));
                    if (cnt != 0) begin
                        check_val($sformatf("data d%0d c%0d", dep[k], cyc),
                                  32'(odata[k]), 32'(srcw[k][delivered[k]]));
                    end
                end
                if (segs[s].thr && oval[0] && ready) thr_cnt++;
                @(posedge clk);
                for (int k = 0; k < ND; k++) begin
                    if (rst || flush) begin
                        arrived[k]   = popped[k];
                        delivered[k] = popped[k];
                    end else begin
                        if (e_del[k]) delivered[k]++;
                        if (e_inf[k]) arrived[k]++;
                        if (e_ack[k]) popped[k]++;
                    end
                    last_ack[k] = e_ack[k];
                end
            end
            if (segs[s].thr) check_val("throughput d3", 32'(thr_cnt), 32'd38);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
